// File: rtl/trap_exit_reporter_pkg.sv
// +----------------------------------------------------------------------------+
// | trap_exit_reporter_pkg                                                     |
// | Shared types and constants for the simulation-exit reporter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package trap_exit_reporter_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EXIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_EBREAK  = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

`default_nettype wire

// File: rtl/trap_exit_reporter_if.sv
// +----------------------------------------------------------------------------+
// | trap_exit_reporter_if                                                      |
// | Commit-port inputs and the exit/counter outputs toward the DEBUG monitor.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface trap_exit_reporter_if #(
  parameter int XLEN = 64
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_inst;
  logic [XLEN-1:0] a0_value;
  logic            sb_empty;

  logic            exit;
  logic [XLEN-1:0] exit_pc;
  logic [XLEN-1:0] exit_a0;
  logic [31:0]     exit_inst;
  logic [1:0]      exit_cause;
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] instret_cnt;

  modport master (
    output commit_valid, commit_pc, commit_inst, a0_value, sb_empty,
    input  exit, exit_pc, exit_a0, exit_inst, exit_cause, cycle_cnt, instret_cnt
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst, a0_value, sb_empty,
    output exit, exit_pc, exit_a0, exit_inst, exit_cause, cycle_cnt, instret_cnt
  );
endinterface

`default_nettype wire

// File: rtl/trap_exit_reporter_exit_watchdog.sv
// +----------------------------------------------------------------------------+
// | exit_watchdog                                                              |
// | No-commit counter with clear/enable and an all-ones flag.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module exit_watchdog #(
  parameter int WDT_W = 20
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_full
);

  logic [WDT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_full = &r_cnt;

endmodule

`default_nettype wire

// File: rtl/trap_exit_reporter.sv
// +----------------------------------------------------------------------------+
// | trap_exit_reporter                                                         |
// | Detects ebreak / commit timeout, drains, then raises a sticky exit report. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module trap_exit_reporter
  import trap_exit_reporter_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int DRAIN_CYC = 4,
  parameter int WDT_W     = 20
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  trap_exit_reporter_if.slave   bus
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] c_DRAIN_INIT = DRAIN_W'(DRAIN_CYC - 1);

  state_t            r_state;
  logic              r_exit;
  logic [XLEN-1:0]   r_exit_pc;
  logic [XLEN-1:0]   r_exit_a0;
  logic [31:0]       r_exit_inst;
  cause_t            r_exit_cause;
  logic [XLEN-1:0]   r_cycle_cnt;
  logic [XLEN-1:0]   r_instret_cnt;
  logic [XLEN-1:0]   r_last_pc;
  logic [31:0]       r_last_inst;
  logic [DRAIN_W-1:0] r_drain;

  logic w_run;
  logic w_is_ebreak;
  logic w_wdt_full;
  logic w_wdt_clr;
  logic w_wdt_en;
  logic w_timeout;

  assign w_run       = (r_state == ST_RUN);
  assign w_is_ebreak = bus.commit_valid && (bus.commit_inst == EBREAK);
  assign w_wdt_clr   = w_run && bus.commit_valid;
  // Stop counting on the timeout cycle so the value stays frozen through DRAIN.
  assign w_wdt_en    = w_run && !bus.commit_valid && !w_wdt_full;
  assign w_timeout   = w_run && !bus.commit_valid && w_wdt_full;

  exit_watchdog #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_wdt_clr),
    .i_en   (w_wdt_en),
    .o_full (w_wdt_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_exit        <= 1'b0;
      r_exit_pc     <= '0;
      r_exit_a0     <= '0;
      r_exit_inst   <= '0;
      r_exit_cause  <= CAUSE_NONE;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
      r_last_pc     <= '0;
      r_last_inst   <= '0;
      r_drain       <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
          if (bus.commit_valid) begin
            r_instret_cnt <= r_instret_cnt + 1'b1;
            r_last_pc     <= bus.commit_pc;
            r_last_inst   <= bus.commit_inst;
          end
          if (w_is_ebreak) begin
            r_exit_pc    <= bus.commit_pc;
            r_exit_inst  <= bus.commit_inst;
            r_exit_a0    <= bus.a0_value;
            r_exit_cause <= CAUSE_EBREAK;
            r_drain      <= c_DRAIN_INIT;
            r_state      <= ST_DRAIN;
          end else if (w_timeout) begin
            r_exit_pc    <= r_last_pc;
            r_exit_inst  <= r_last_inst;
            r_exit_a0    <= {XLEN{1'b1}};
            r_exit_cause <= CAUSE_TIMEOUT;
            r_drain      <= c_DRAIN_INIT;
            r_state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
          if (r_drain != '0) begin
            r_drain <= r_drain - 1'b1;
          end else if (bus.sb_empty) begin
            r_exit  <= 1'b1;
            r_state <= ST_EXIT;
          end
        end
        ST_EXIT: begin
          r_exit <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.exit        = r_exit;
  assign bus.exit_pc     = r_exit_pc;
  assign bus.exit_a0     = r_exit_a0;
  assign bus.exit_inst   = r_exit_inst;
  assign bus.exit_cause  = r_exit_cause;
  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.instret_cnt = r_instret_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trap_exit_reporter.sv
// +----------------------------------------------------------------------------+
// | tb_trap_exit_reporter                                                      |
// | Directed vectors plus hand sequences for drain, timeout and reset cases.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_trap_exit_reporter;

  localparam logic [31:0] EB  = 32'h0010_0073;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  trap_exit_reporter_if #(.XLEN(64)) bus ();

  trap_exit_reporter #(
    .XLEN      (64),
    .DRAIN_CYC (4),
    .WDT_W     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst;
    bit          cv;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] a0;
    bit          sb;
    bit          e_exit;
    logic [63:0] e_pc;
    logic [63:0] e_a0;
    logic [31:0] e_inst;
    logic [1:0]  e_cause;
    logic [63:0] e_cyc;
    logic [63:0] e_ret;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit cv, input logic [63:0] pc, input logic [31:0] inst,
                       input logic [63:0] a0, input bit sb);
    bus.commit_valid = cv;
    bus.commit_pc    = pc;
    bus.commit_inst  = inst;
    bus.a0_value     = a0;
    bus.sb_empty     = sb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 64'h0, 1'b1);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 64'h0, 1'b1);

    //        rst cv pc              inst a0     sb  exit e_pc            e_a0    e_inst e_cause cyc ret
    tbl[0]  = '{1, 1, 64'h8000_0000, NOP, 64'h5,  1,  0, 64'h0,          64'h0,  32'h0, 2'd0, 64'd1, 64'd1};
    tbl[1]  = '{0, 1, 64'h8000_0004, NOP, 64'h5,  1,  0, 64'h0,          64'h0,  32'h0, 2'd0, 64'd2, 64'd2};
    tbl[2]  = '{0, 0, 64'h0,         NOP, 64'h5,  1,  0, 64'h0,          64'h0,  32'h0, 2'd0, 64'd3, 64'd2};
    tbl[3]  = '{0, 1, 64'h8000_0010, EB,  64'h0,  1,  0, 64'h8000_0010,  64'h0,  EB,    2'd1, 64'd4, 64'd3};
    tbl[4]  = '{0, 1, 64'h8000_0014, NOP, 64'h9,  1,  0, 64'h8000_0010,  64'h0,  EB,    2'd1, 64'd5, 64'd3};
    tbl[5]  = '{0, 1, 64'h8000_0018, NOP, 64'h9,  1,  0, 64'h8000_0010,  64'h0,  EB,    2'd1, 64'd6, 64'd3};
    tbl[6]  = '{0, 0, 64'h0,         NOP, 64'h9,  1,  0, 64'h8000_0010,  64'h0,  EB,    2'd1, 64'd7, 64'd3};
    tbl[7]  = '{0, 0, 64'h0,         NOP, 64'h9,  1,  1, 64'h8000_0010,  64'h0,  EB,    2'd1, 64'd8, 64'd3};
    tbl[8]  = '{0, 1, 64'h8000_001c, NOP, 64'h9,  1,  1, 64'h8000_0010,  64'h0,  EB,    2'd1, 64'd8, 64'd3};
    tbl[9]  = '{1, 1, 64'h8000_0200, EB,  64'h2A, 1,  0, 64'h8000_0200,  64'h2A, EB,    2'd1, 64'd1, 64'd1};
    tbl[10] = '{0, 1, 64'h8000_0204, NOP, 64'h3,  1,  0, 64'h8000_0200,  64'h2A, EB,    2'd1, 64'd2, 64'd1};
    tbl[11] = '{0, 1, 64'h8000_0208, NOP, 64'h3,  1,  0, 64'h8000_0200,  64'h2A, EB,    2'd1, 64'd3, 64'd1};
    tbl[12] = '{0, 1, 64'h8000_020c, NOP, 64'h3,  1,  0, 64'h8000_0200,  64'h2A, EB,    2'd1, 64'd4, 64'd1};
    tbl[13] = '{0, 1, 64'h8000_0210, NOP, 64'h3,  1,  1, 64'h8000_0200,  64'h2A, EB,    2'd1, 64'd5, 64'd1};

    #2;
    chk("rst_exit",    64'(bus.exit),        64'h0);
    chk("rst_pc",      bus.exit_pc,          64'h0);
    chk("rst_a0",      bus.exit_a0,          64'h0);
    chk("rst_inst",    64'(bus.exit_inst),   64'h0);
    chk("rst_cause",   64'(bus.exit_cause),  64'h0);
    chk("rst_cycle",   bus.cycle_cnt,        64'h0);
    chk("rst_instret", bus.instret_cnt,      64'h0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].cv, tbl[i].pc, tbl[i].inst, tbl[i].a0, tbl[i].sb);
      step();
      chk($sformatf("v%0d_exit", i),    64'(bus.exit),       64'(tbl[i].e_exit));
      chk($sformatf("v%0d_pc", i),      bus.exit_pc,         tbl[i].e_pc);
      chk($sformatf("v%0d_a0", i),      bus.exit_a0,         tbl[i].e_a0);
      chk($sformatf("v%0d_inst", i),    64'(bus.exit_inst),  64'(tbl[i].e_inst));
      chk($sformatf("v%0d_cause", i),   64'(bus.exit_cause), 64'(tbl[i].e_cause));
      chk($sformatf("v%0d_cycle", i),   bus.cycle_cnt,       tbl[i].e_cyc);
      chk($sformatf("v%0d_instret", i), bus.instret_cnt,     tbl[i].e_ret);
    end

    // Drain expires but the store buffer stays busy for 10 more cycles.
    do_reset();
    drive(1'b1, 64'h8000_0300, EB, 64'h0, 1'b0);
    step();
    drive(1'b0, 64'h0, NOP, 64'h0, 1'b0);
    repeat (3) step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("sb_hold%0d_exit", k), 64'(bus.exit), 64'h0);
    end
    bus.sb_empty = 1'b1;
    step();
    chk("sb_release_exit", 64'(bus.exit), 64'h1);
    chk("sb_release_pc",   bus.exit_pc,   64'h8000_0300);

    // Watchdog: one commit then idle; all-ones after 15 idle edges, capture on the next.
    do_reset();
    drive(1'b1, 64'h8000_0100, NOP, 64'h5, 1'b1);
    step();
    drive(1'b0, 64'h0, 32'h0, 64'h0, 1'b1);
    repeat (15) step();
    chk("wdt_pre_cause", 64'(bus.exit_cause), 64'h0);
    step();
    chk("wdt_cause", 64'(bus.exit_cause), 64'h2);
    chk("wdt_a0",    bus.exit_a0,         64'hFFFF_FFFF_FFFF_FFFF);
    chk("wdt_pc",    bus.exit_pc,         64'h8000_0100);
    chk("wdt_inst",  64'(bus.exit_inst),  64'(NOP));
    chk("wdt_exit0", 64'(bus.exit),       64'h0);
    repeat (3) step();
    chk("wdt_exit_pre", 64'(bus.exit), 64'h0);
    step();
    chk("wdt_exit", 64'(bus.exit), 64'h1);
    chk("wdt_instret", bus.instret_cnt, 64'h1);

    // Asynchronous reset while draining.
    do_reset();
    drive(1'b1, 64'h8000_0400, EB, 64'h55, 1'b1);
    step();
    drive(1'b0, 64'h0, 32'h0, 64'h0, 1'b1);
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_exit",    64'(bus.exit),       64'h0);
    chk("arst_pc",      bus.exit_pc,         64'h0);
    chk("arst_a0",      bus.exit_a0,         64'h0);
    chk("arst_cause",   64'(bus.exit_cause), 64'h0);
    chk("arst_cycle",   bus.cycle_cnt,       64'h0);
    chk("arst_instret", bus.instret_cnt,     64'h0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 64'h8000_0500, EB, 64'h0, 1'b1);
    step();
    drive(1'b0, 64'h0, 32'h0, 64'h0, 1'b1);
    repeat (3) step();
    chk("post_rst_exit_pre", 64'(bus.exit), 64'h0);
    step();
    chk("post_rst_exit",    64'(bus.exit),   64'h1);
    chk("post_rst_pc",      bus.exit_pc,     64'h8000_0500);
    chk("post_rst_instret", bus.instret_cnt, 64'h1);
    chk("post_rst_cycle",   bus.cycle_cnt,   64'd5);

    // 100 commits then ebreak with no stalls.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), NOP, 64'(i), 1'b1);
      step();
    end
    drive(1'b1, 64'h8000_0190, EB, 64'h0, 1'b1);
    step();
    chk("run100_instret", bus.instret_cnt, 64'd101);
    drive(1'b0, 64'h0, 32'h0, 64'h0, 1'b1);
    repeat (4) step();
    chk("run100_exit",  64'(bus.exit), 64'h1);
    chk("run100_pc",    bus.exit_pc,   64'h8000_0190);
    chk("run100_cycle", bus.cycle_cnt, 64'd105);
    drive(1'b1, 64'h8000_0194, NOP, 64'h0, 1'b1);
    repeat (5) step();
    chk("run100_cycle_frozen",   bus.cycle_cnt,   64'd105);
    chk("run100_instret_frozen", bus.instret_cnt, 64'd101);
    chk("run100_exit_sticky",    64'(bus.exit),   64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
